// File: rtl/seq_det_feeder_if.sv
// Host/detector-side signal bundle for the bit-serial feeder.
// The master side is the host plus the detector; the slave side is the feeder itself.
interface seq_det_feeder_if #(
  parameter int DATA_W = 8,
  parameter int WCNT_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [WCNT_W-1:0] num_words;
  logic [CNT_W-1:0]  threshold;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              det_din;
  logic              det_flag;
  logic              busy;
  logic [CNT_W-1:0]  hit_cnt;
  logic              match;
  logic              done;
  logic              underrun;

  modport master (
    output start, num_words, threshold, in_data, in_valid, det_flag,
    input  in_ready, det_din, busy, hit_cnt, match, done, underrun
  );

  modport slave (
    input  start, num_words, threshold, in_data, in_valid, det_flag,
    output in_ready, det_din, busy, hit_cnt, match, done, underrun
  );
endinterface

// File: rtl/seq_det_feeder.sv
// Bit-serial feeder for a free-running 01010101 Moore detector.
// Run shape: 3 flush ones, N words MSB-first back-to-back, 2 drain zeros, done.
// Flags landing in SHIFT/DRAIN are counted; flush-induced flags are ignored.
module seq_det_feeder #(
  parameter int DATA_W = 8,
  parameter int WCNT_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_det_feeder_if.slave bus
);

  // phase doubles as flush counter (0..2), bit index (0..DATA_W-1), drain counter (0..1)
  localparam int PH_W = (DATA_W > 4) ? $clog2(DATA_W) : 2;
  localparam logic [PH_W-1:0] PH_BIT_LAST   = PH_W'(DATA_W - 1);
  localparam logic [PH_W-1:0] PH_FLUSH_LAST = PH_W'(2);
  localparam logic [PH_W-1:0] PH_DRAIN_LAST = PH_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state, state_n;
  logic [PH_W-1:0]   phase, phase_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [WCNT_W-1:0] left, left_n;     // words still to be accepted
  logic [CNT_W-1:0]  thr, hits;
  logic              din_q, busy_q, done_q, match_q, under_q;
  logic              slot, take, starve, count_en;

  // A word slot opens on the cycle before the next bit is needed, so a
  // handshake there keeps det_din streaming without a gap.
  assign slot   = (((state == FLUSH) && (phase == PH_FLUSH_LAST)) ||
                   ((state == SHIFT) && (phase == PH_BIT_LAST))) && (left != '0);
  assign take   = slot & bus.in_valid;
  assign starve = slot & ~bus.in_valid;

  // The detector's 2-cycle latency means flags in SHIFT/DRAIN belong to this run.
  assign count_en = ((state == SHIFT) || (state == DRAIN)) && bus.det_flag && (hits != '1);

  // Next-state, phase, shift register and word budget.
  always_comb begin
    state_n = state;
    phase_n = phase + PH_W'(1);
    shreg_n = shreg;
    left_n  = left;
    case (state)
      IDLE: begin
        phase_n = '0;
        if (bus.start) begin
          state_n = FLUSH;
          left_n  = bus.num_words;
        end
      end
      FLUSH: begin
        if (phase == PH_FLUSH_LAST) begin
          phase_n = '0;
          state_n = take ? SHIFT : DRAIN;
        end
      end
      SHIFT: begin
        shreg_n = shreg << 1;
        if (phase == PH_BIT_LAST) begin
          phase_n = '0;
          state_n = take ? SHIFT : DRAIN;
        end
      end
      DRAIN: begin
        if (phase == PH_DRAIN_LAST) begin
          phase_n = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase
    if (take) begin
      shreg_n = bus.in_data;
      left_n  = left - WCNT_W'(1);
    end
  end

  // Sequencer registers; det_din/busy/done are registered from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      phase  <= '0;
      shreg  <= '0;
      left   <= '0;
      din_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      shreg  <= shreg_n;
      left   <= left_n;
      din_q  <= (state_n == FLUSH) | ((state_n == SHIFT) & shreg_n[DATA_W-1]);
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == DRAIN) && (phase_n == PH_DRAIN_LAST);
    end
  end

  // Run accounting: threshold latch, saturating hit count, match pulse, sticky underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr     <= '0;
      hits    <= '0;
      match_q <= 1'b0;
      under_q <= 1'b0;
    end else if ((state == IDLE) && bus.start) begin
      thr     <= bus.threshold;
      hits    <= '0;
      match_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      match_q <= count_en && (thr != '0) && ((hits + CNT_W'(1)) == thr);
      if (count_en) hits <= hits + CNT_W'(1);
      if (starve) under_q <= 1'b1;
    end
  end

  assign bus.in_ready = slot;
  assign bus.det_din  = din_q;
  assign bus.busy     = busy_q;
  assign bus.hit_cnt  = hits;
  assign bus.match    = match_q;
  assign bus.done     = done_q;
  assign bus.underrun = under_q;

endmodule

// File: tb/tb_seq_det_feeder.sv
// Bench for seq_det_feeder: table of directed runs with hand-derived results,
// randomized runs checked against a bit-stream window model, and a mid-run reset.
module tb_seq_det_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_det_feeder_if #(.DATA_W(8), .WCNT_W(8), .CNT_W(8)) bus ();

  seq_det_feeder #(.DATA_W(8), .WCNT_W(8), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Detector stand-in: flag two cycles after the bit completing 01010101.
  logic [7:0] win;
  logic       p1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win          <= 8'hFF;
      p1           <= 1'b0;
      bus.det_flag <= 1'b0;
    end else begin
      win          <= {win[6:0], bus.det_din};
      p1           <= ({win[6:0], bus.det_din} == 8'h55);
      bus.det_flag <= p1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] wq [0:127];

  typedef struct {
    int n; int thr; int drop;
    logic [7:0] w0; logic [7:0] w1; logic [7:0] w2;
    int hits; int done_at; bit under; int match; bit poke;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: count 8-bit windows equal to 01010101 over the accepted words.
  function automatic int model_hits(input int k);
    logic [7:0] w;
    int c;
    w = 8'hFF;
    c = 0;
    for (int i = 0; i < k; i++)
      for (int b = 7; b >= 0; b--) begin
        w = {w[6:0], wq[i][b]};
        if (w == 8'h55 && c < 255) c++;
      end
    return c;
  endfunction

  task automatic run(input string tag, input int n, input int thr, input int drop,
                     input int exp_hits, input int exp_done, input bit exp_under,
                     input int exp_match, input bit poke);
    bit q[$];
    int k, idx, done_cyc, ndone, mc, rdy, bad_cyc, hit_at_match, busy1, busy_after;
    bit exp_bit;
    k = (drop < n) ? drop : n;
    q.delete();
    repeat (3) q.push_back(1'b1);
    for (int i = 0; i < k; i++)
      for (int b = 7; b >= 0; b--) q.push_back(wq[i][b]);
    q.push_back(1'b0);
    q.push_back(1'b0);
    idx = 0; done_cyc = -1; ndone = 0; mc = 0; rdy = 0; bad_cyc = 0;
    hit_at_match = -1; busy1 = 0; busy_after = 1;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_words = 8'(n);
    bus.threshold = 8'(thr);
    bus.in_valid  = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 8 * n + 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start     = 1'b0;
        bus.num_words = 8'd7;
        bus.threshold = 8'd1;
      end
      if (poke && cyc == 2) begin bus.start = 1'b1; bus.num_words = 8'd0; end
      if (poke && cyc == 3) bus.start = 1'b0;
      bus.in_valid = (idx < n) && (idx != drop);
      bus.in_data  = (idx < n) ? wq[idx] : 8'($urandom);
      exp_bit = (cyc - 1 < q.size()) ? q[cyc-1] : 1'b0;
      if (bus.det_din !== exp_bit && bad_cyc == 0) bad_cyc = cyc;
      if (cyc == 1) busy1 = bus.busy;
      if (bus.in_ready) begin
        rdy++;
        if (bus.in_valid) idx++;
      end
      if (bus.match) begin mc++; hit_at_match = bus.hit_cnt; end
      if (bus.done) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc > 0 && cyc == done_cyc + 1) busy_after = bus.busy;
      if (done_cyc > 0 && cyc == done_cyc + 2) break;
    end
    chk({tag, " det_din first bad cycle"}, bad_cyc, 0);
    chk({tag, " done cycle"}, done_cyc, exp_done);
    chk({tag, " done pulses"}, ndone, 1);
    chk({tag, " busy after start"}, busy1, 1);
    chk({tag, " busy after done"}, busy_after, 0);
    chk({tag, " hit_cnt"}, bus.hit_cnt, exp_hits);
    chk({tag, " underrun"}, bus.underrun, exp_under);
    chk({tag, " match pulses"}, mc, exp_match);
    chk({tag, " in_ready cycles"}, rdy, (drop < n) ? drop + 1 : n);
    if (exp_match > 0) chk({tag, " hit_cnt at match"}, hit_at_match, thr);
  endtask

  initial begin
    int n, thr, drop, k, h;
    logic [7:0] pool [4];
    bus.start = 1'b0; bus.num_words = '0; bus.threshold = '0;
    bus.in_data = '0; bus.in_valid = 1'b0;

    //       n   thr  drop  w0     w1     w2     hits done und m poke
    tbl[0] = '{1,  0,   9,  8'h55, 8'h00, 8'h00, 1,   13,  0,  0, 0};
    tbl[1] = '{2,  5,   9,  8'h55, 8'h55, 8'h00, 5,   21,  0,  1, 0};
    tbl[2] = '{1,  0,   9,  8'h2A, 8'h00, 8'h00, 0,   13,  0,  0, 0};
    tbl[3] = '{1,  0,   9,  8'h00, 8'h00, 8'h00, 0,   13,  0,  0, 0};
    tbl[4] = '{3,  2,   1,  8'h55, 8'h55, 8'h55, 1,   13,  1,  0, 0};
    tbl[5] = '{0,  1,   9,  8'h00, 8'h00, 8'h00, 0,   5,   0,  0, 1};
    tbl[6] = '{1,  1,   9,  8'h55, 8'h00, 8'h00, 1,   13,  0,  1, 1};
    tbl[7] = '{1,  0,   0,  8'h55, 8'h00, 8'h00, 0,   5,   1,  0, 0};
    tbl[8] = '{2,  2,   9,  8'h0A, 8'hAA, 8'h00, 3,   21,  0,  1, 0};
    tbl[9] = '{80, 255, 99, 8'h55, 8'h55, 8'h55, 255, 645, 0,  1, 0};

    repeat (3) @(negedge clk);
    chk("reset outputs", {bus.busy, bus.in_ready, bus.det_din, bus.match, bus.done,
                          bus.underrun, bus.hit_cnt}, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 128; i++)
        wq[i] = (i == 0) ? tbl[t].w0 : (i == 1) ? tbl[t].w1 : tbl[t].w2;
      run($sformatf("vec%0d", t), tbl[t].n, tbl[t].thr, tbl[t].drop, tbl[t].hits,
          tbl[t].done_at, tbl[t].under, tbl[t].match, tbl[t].poke);
    end

    pool[0] = 8'h55; pool[1] = 8'hAA; pool[2] = 8'h2A; pool[3] = 8'h95;
    for (int r = 0; r < 24; r++) begin
      n    = $urandom_range(0, 4);
      thr  = $urandom_range(0, 5);
      drop = $urandom_range(0, 7);
      for (int i = 0; i < 4; i++)
        wq[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 3)];
      k = (drop < n) ? drop : n;
      h = model_hits(k);
      run($sformatf("rnd%0d", r), n, thr, drop, h, 5 + 8 * k, drop < n,
          (thr != 0 && h >= thr) ? 1 : 0, r[0]);
    end

    // Reset in the middle of a 3-word run, after some hits have accrued.
    for (int i = 0; i < 4; i++) wq[i] = 8'h55;
    @(negedge clk);
    bus.start = 1'b1; bus.num_words = 8'd3; bus.threshold = 8'd0;
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre-reset hit_cnt", bus.hit_cnt, 4);
    chk("pre-reset busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid-run reset outputs", {bus.busy, bus.in_ready, bus.det_din, bus.done,
                                  bus.underrun, bus.hit_cnt}, 0);
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus.done || bus.busy) seen++;
      end
      chk("no done/busy under reset", seen, 0);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    wq[0] = 8'h55;
    run("post-reset", 1, 1, 9, 1, 13, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
